// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: accepts a header plus data and instruction words over a
// valid/ready stream, writes them into the data and instruction BRAMs, then
// releases the rv32i core by dropping the PC stall and enabling read ports.
module boot_loader_ctrl #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [7:0]  MAGIC       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  output logic                  s_ready,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [31:0]           i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [31:0]           d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  busy,
  output logic                  error
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS) + 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    HDR,
    LOAD_DATA,
    LOAD_INSTR,
    FLUSH,
    RUN,
    ERROR
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  n_instr_q;
  logic [IDX_W-1:0]  n_data_q;

  logic              xfer;
  logic [7:0]        hdr_magic;
  logic [11:0]       hdr_ni;
  logic [11:0]       hdr_nd;
  logic              hdr_ok;
  logic [31:0]       idx_x4;
  logic [ADDR_WIDTH-1:0] idx_addr;

  // Stream handshake, header decode and word-index arithmetic.
  always_comb begin
    s_ready   = (state == HDR) || (state == LOAD_DATA) || (state == LOAD_INSTR);
    xfer      = s_valid && s_ready;
    hdr_magic = s_data[31:24];
    hdr_ni    = s_data[23:12];
    hdr_nd    = s_data[11:0];
    hdr_ok    = (hdr_magic == MAGIC) &&
                (hdr_ni != 12'd0) &&
                (32'(hdr_ni) <= DEPTH_L) &&
                (32'(hdr_nd) <= DEPTH_L);
    idx_nxt   = idx + IDX_W'(1);
    idx_x4    = 32'(idx) << 2;
    idx_addr  = idx_x4[ADDR_WIDTH-1:0];
  end

  // Loader FSM; every output except s_ready is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= HDR;
      idx              <= '0;
      n_instr_q        <= '0;
      n_data_q         <= '0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      d_bram_init_done <= 1'b0;
      pc_stall         <= 1'b1;
      i_r_enb          <= 1'b0;
      rd_enbl          <= 1'b0;
      busy             <= 1'b1;
      error            <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses; they only rise on a transfer.
      d_w_enb <= 1'b0;
      i_w_enb <= 1'b0;

      case (state)
        HDR: begin
          if (xfer) begin
            idx       <= '0;
            n_instr_q <= IDX_W'(hdr_ni);
            n_data_q  <= IDX_W'(hdr_nd);
            if (!hdr_ok) begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (hdr_nd == 12'd0) begin
              state <= LOAD_INSTR;
            end else begin
              state <= LOAD_DATA;
            end
          end
        end

        LOAD_DATA: begin
          if (xfer) begin
            d_w_addr <= idx_addr;
            d_w_dat  <= s_data;
            d_w_enb  <= 1'b1;
            if (idx_nxt == n_data_q) begin
              idx   <= '0;
              state <= LOAD_INSTR;
            end else begin
              idx <= idx_nxt;
            end
          end
        end

        LOAD_INSTR: begin
          if (xfer) begin
            i_w_addr <= idx_addr;
            i_w_dat  <= s_data;
            i_w_enb  <= 1'b1;
            if (idx_nxt == n_instr_q) begin
              idx   <= '0;
              state <= FLUSH;
            end else begin
              idx <= idx_nxt;
            end
          end
        end

        FLUSH: begin
          state            <= RUN;
          pc_stall         <= 1'b0;
          i_r_enb          <= 1'b1;
          rd_enbl          <= 1'b1;
          d_bram_init_done <= 1'b1;
          busy             <= 1'b0;
        end

        RUN: begin
          if (restart) begin
            state            <= HDR;
            idx              <= '0;
            n_instr_q        <= '0;
            n_data_q         <= '0;
            pc_stall         <= 1'b1;
            i_r_enb          <= 1'b0;
            rd_enbl          <= 1'b0;
            d_bram_init_done <= 1'b0;
            busy             <= 1'b1;
          end
        end

        ERROR: begin
          if (restart) begin
            state     <= HDR;
            idx       <= '0;
            n_instr_q <= '0;
            n_data_q  <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end

        default: begin
          state <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: expected BRAM writes are queued
// as words are driven and popped by a monitor when write enables pulse.
module tb_boot_loader_ctrl;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          restart;
  logic [AW-1:0] i_w_addr;
  logic [31:0]   i_w_dat;
  logic          i_w_enb;
  logic [AW-1:0] d_w_addr;
  logic [31:0]   d_w_dat;
  logic          d_w_enb;
  logic          d_bram_init_done;
  logic          pc_stall;
  logic          i_r_enb;
  logic          rd_enbl;
  logic          busy;
  logic          error;

  int total = 0;
  int bad   = 0;

  logic [AW+31:0] exp_d[$];
  logic [AW+31:0] exp_i[$];

  boot_loader_ctrl #(
    .DEPTH_WORDS(256),
    .ADDR_WIDTH (AW),
    .MAGIC      (8'hA5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .restart         (restart),
    .i_w_addr        (i_w_addr),
    .i_w_dat         (i_w_dat),
    .i_w_enb         (i_w_enb),
    .d_w_addr        (d_w_addr),
    .d_w_dat         (d_w_dat),
    .d_w_enb         (d_w_enb),
    .d_bram_init_done(d_bram_init_done),
    .pc_stall        (pc_stall),
    .i_r_enb         (i_r_enb),
    .rd_enbl         (rd_enbl),
    .busy            (busy),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Write-port monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (d_w_enb) begin
      total++;
      if (exp_d.size() == 0) begin
        bad++;
        $display("FAIL d_write_unexpected: got addr=%h dat=%h want no write", d_w_addr, d_w_dat);
      end else begin
        logic [AW+31:0] e;
        e = exp_d.pop_front();
        if ({d_w_addr, d_w_dat} !== e) begin
          bad++;
          $display("FAIL d_write: got %h_%h want %h_%h", d_w_addr, d_w_dat, e[AW+31:32], e[31:0]);
        end
      end
    end
    if (i_w_enb) begin
      total++;
      if (exp_i.size() == 0) begin
        bad++;
        $display("FAIL i_write_unexpected: got addr=%h dat=%h want no write", i_w_addr, i_w_dat);
      end else begin
        logic [AW+31:0] e;
        e = exp_i.pop_front();
        if ({i_w_addr, i_w_dat} !== e) begin
          bad++;
          $display("FAIL i_write: got %h_%h want %h_%h", i_w_addr, i_w_dat, e[AW+31:32], e[31:0]);
        end
      end
    end
    if (d_w_enb && i_w_enb) begin
      total++;
      bad++;
      $display("FAIL dual_enable: got d=%b i=%b want at most one", d_w_enb, i_w_enb);
    end
  end

  task automatic send(input logic [31:0] w);
    int unsigned n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got s_ready=%b want 1", s_ready);
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_d(input int k, input logic [31:0] w);
    exp_d.push_back({AW'(k * 4), w});
    send(w);
  endtask

  task automatic send_i(input int k, input logic [31:0] w);
    exp_i.push_back({AW'(k * 4), w});
    send(w);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_d.size() != 0 || exp_i.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: got d=%0d i=%0d pending want 0 0", name, exp_d.size(), exp_i.size());
    end
  endtask

  // Last transfer just happened: expect FLUSH now, RUN after one more edge.
  task automatic check_flush_then_run(input string name);
    total++;
    if ({pc_stall, busy, s_ready, d_bram_init_done} !== 4'b1100) begin
      bad++;
      $display("FAIL %s_flush: got stall/busy/rdy/init=%b want 1100",
               name, {pc_stall, busy, s_ready, d_bram_init_done});
    end
    @(posedge clk); #1;
    total++;
    if ({pc_stall, i_r_enb, rd_enbl, d_bram_init_done, busy, error, s_ready} !== 7'b0111000) begin
      bad++;
      $display("FAIL %s_run: got %b want 0111000", name,
               {pc_stall, i_r_enb, rd_enbl, d_bram_init_done, busy, error, s_ready});
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if ({pc_stall, busy, error, d_bram_init_done, i_r_enb, rd_enbl, d_w_enb, i_w_enb, s_ready}
        !== 9'b110000001) begin
      bad++;
      $display("FAIL %s_flags: got %b want 110000001", name,
               {pc_stall, busy, error, d_bram_init_done, i_r_enb, rd_enbl, d_w_enb, i_w_enb, s_ready});
    end
    total++;
    if ({d_w_addr, d_w_dat, i_w_addr, i_w_dat} !== '0) begin
      bad++;
      $display("FAIL %s_ports: got d=%h/%h i=%h/%h want zeros", name, d_w_addr, d_w_dat, i_w_addr, i_w_dat);
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset");
  endtask

  task automatic test_happy_path();
    logic [31:0] prog [8];
    prog = '{32'h00500293, 32'h00600313, 32'h00100393, 32'h00702623,
             32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013};
    send(32'hA5008003);
    total++;
    if ({s_ready, busy, d_w_enb, i_w_enb} !== 4'b1100) begin
      bad++;
      $display("FAIL happy_hdr: got rdy/busy/den/ien=%b want 1100", {s_ready, busy, d_w_enb, i_w_enb});
    end
    for (int k = 0; k < 3; k++) send_d(k, 32'hD0000000 + 32'(k));
    for (int k = 0; k < 8; k++) send_i(k, prog[k]);
    check_flush_then_run("happy");
    check_drained("happy");
  endtask

  task automatic test_restart_from_run();
    pulse_restart();
    total++;
    if ({pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy, s_ready} !== 6'b100011) begin
      bad++;
      $display("FAIL restart_run: got %b want 100011",
               {pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy, s_ready});
    end
  endtask

  task automatic test_no_data();
    send(32'hA5002000);
    total++;
    if ({s_ready, busy, pc_stall} !== 3'b111) begin
      bad++;
      $display("FAIL nodata_hdr: got %b want 111", {s_ready, busy, pc_stall});
    end
    send_i(0, 32'h11111111);
    send_i(1, 32'h22222222);
    check_flush_then_run("nodata");
    check_drained("nodata");
  endtask

  task automatic bad_header(input string name, input logic [31:0] hdr);
    send(hdr);
    total++;
    if ({error, s_ready, pc_stall, busy} !== 4'b1010) begin
      bad++;
      $display("FAIL %s_err: got err/rdy/stall/busy=%b want 1010", name, {error, s_ready, pc_stall, busy});
    end
    // Offered words in ERROR must be refused without any write.
    s_valid = 1'b1;
    s_data  = 32'hA5001001;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    total++;
    if ({error, s_ready} !== 2'b10) begin
      bad++;
      $display("FAIL %s_hold: got err/rdy=%b want 10", name, {error, s_ready});
    end
    pulse_restart();
    total++;
    if ({error, s_ready, busy, pc_stall} !== 4'b0111) begin
      bad++;
      $display("FAIL %s_restart: got err/rdy/busy/stall=%b want 0111", name, {error, s_ready, busy, pc_stall});
    end
  endtask

  task automatic test_bad_headers();
    bad_header("bad_magic", 32'h5A008003);
    bad_header("ninstr0", 32'hA5000003);
    bad_header("ninstr257", 32'hA5101001);
    check_drained("badhdr");
  endtask

  task automatic test_gapped();
    send(32'hA5001004);
    send_d(0, 32'hCAFE0000);
    send_d(1, 32'hCAFE0001);
    // Two idle cycles; a restart here arrives while busy and must be ignored.
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, s_ready, d_w_enb} !== 3'b110) begin
      bad++;
      $display("FAIL gap_idle: got busy/rdy/den=%b want 110", {busy, s_ready, d_w_enb});
    end
    send_d(2, 32'hCAFE0002);
    send_d(3, 32'hCAFE0003);
    send_i(0, 32'h0BADF00D);
    check_flush_then_run("gapped");
    check_drained("gapped");
  endtask

  task automatic test_full_data_depth();
    send(32'hA5001100);
    for (int k = 0; k < 256; k++) send_d(k, 32'h5A000000 ^ 32'(k * 32'h01010101));
    send_i(0, 32'h00000013);
    check_flush_then_run("depth");
    check_drained("depth");
  endtask

  task automatic test_reset_mid_load();
    send(32'hA5008000);
    send_i(0, 32'hAAAA0000);
    send_i(1, 32'hAAAA0001);
    // Third word offered on the same edge as reset: its pulse must not appear.
    s_valid = 1'b1;
    s_data  = 32'hAAAA0002;
    rst     = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst     = 1'b0;
    s_valid = 1'b0;
    check_drained("midrst");
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;

    test_happy_path();
    test_restart_from_run();
    test_no_data();
    test_restart_from_run();
    test_bad_headers();
    test_gapped();
    test_restart_from_run();
    test_full_data_depth();
    test_restart_from_run();
    test_reset_mid_load();
    test_happy_path();
    test_restart_from_run();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
